// File: rtl/pong_game_ctrl.sv
// Pong match controller: sequences IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER),
// keeps both scores and drives the ball recenter/run controls.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frameTick,
  input  logic       startBtn,
  input  logic       missL,
  input  logic       missR,
  output logic       ballRst,
  output logic       ballRun,
  output logic       serveDir,
  output logic [3:0] scoreL,
  output logic [3:0] scoreR,
  output logic       gameOver,
  output logic       winner,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

  // Scores saturate at the winning value so a stray miss can never overshoot it.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN_VAL) ? WIN_VAL : s + 4'd1;
  endfunction

  logic       start_btn_q;
  logic       start_edge;
  logic [7:0] frame_cnt;
  logic [7:0] frame_cnt_nxt;
  logic [2:0] state_nxt;
  logic [3:0] score_l_nxt;
  logic [3:0] score_r_nxt;
  logic       serve_dir_nxt;
  logic       state_chg;
  logic       ball_rst_q;
  logic       tick_last_serve;
  logic       tick_last_point;

  assign start_edge      = startBtn & ~start_btn_q;
  assign tick_last_serve = frameTick && (frame_cnt == SERVE_LAST);
  assign tick_last_point = frameTick && (frame_cnt == POINT_LAST);

  always_comb begin
    state_nxt     = state;
    score_l_nxt   = scoreL;
    score_r_nxt   = scoreR;
    serve_dir_nxt = serveDir;
    if (enable) begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            score_l_nxt   = 4'd0;
            score_r_nxt   = 4'd0;
            serve_dir_nxt = 1'b0;
            state_nxt     = ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (tick_last_serve) state_nxt = ST_PLAY;
        end
        ST_PLAY: begin
          if (missL && missR) begin
            state_nxt = ST_POINT;
          end else if (missL) begin
            score_r_nxt   = sat_inc(scoreR);
            serve_dir_nxt = 1'b0;
            state_nxt     = ST_POINT;
          end else if (missR) begin
            score_l_nxt   = sat_inc(scoreL);
            serve_dir_nxt = 1'b1;
            state_nxt     = ST_POINT;
          end
        end
        ST_POINT: begin
          if (tick_last_point) begin
            if ((scoreL == WIN_VAL) || (scoreR == WIN_VAL)) state_nxt = ST_OVER;
            else                                           state_nxt = ST_SERVE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign state_chg = (state_nxt != state);

  // A tick coinciding with a state change belongs to the old state and is dropped.
  always_comb begin
    frame_cnt_nxt = frame_cnt;
    if (enable) begin
      if (state_chg)      frame_cnt_nxt = 8'd0;
      else if (frameTick) frame_cnt_nxt = frame_cnt + 8'd1;
    end
  end

  // Button history resets high so a button held through reset cannot start a game.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_btn_q <= 1'b1;
      state       <= ST_IDLE;
      frame_cnt   <= 8'd0;
      scoreL      <= 4'd0;
      scoreR      <= 4'd0;
      serveDir    <= 1'b0;
      ball_rst_q  <= 1'b0;
    end else begin
      start_btn_q <= startBtn;
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      scoreL      <= score_l_nxt;
      scoreR      <= score_r_nxt;
      serveDir    <= serve_dir_nxt;
      ball_rst_q  <= enable && state_chg && (state_nxt == ST_SERVE);
    end
  end

  assign ballRst  = ball_rst_q & enable;
  assign ballRun  = enable && (state == ST_PLAY);
  assign gameOver = (state == ST_OVER);
  assign winner   = (state == ST_OVER) && (scoreR == WIN_VAL);

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, points to win (1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, frames held in SERVE before play (1..255).
REQ-003 SHALL have parameter POINT_FRAMES, default 30, frames held in POINT after a miss (1..255).
REQ-004 SHALL have port clk  input  1  system clock; all logic single-domain on clk.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  game run enable.
REQ-007 SHALL have port frameTick  input  1  one-clk pulse per video frame, already in clk domain.
REQ-008 SHALL have port startBtn  input  1  debounced start button level.
REQ-009 SHALL have port missL  input  1  ball passed left paddle.
REQ-010 SHALL have port missR  input  1  ball passed right paddle.
REQ-011 SHALL have port ballRst  output  1  one-clk pulse: recenter ball.
REQ-012 SHALL have port ballRun  output  1  ball motion enable.
REQ-013 SHALL have port serveDir  output  1  serve direction: 0 = toward left, 1 = toward right.
REQ-014 SHALL have port scoreL, scoreR  output  4  player scores.
REQ-015 SHALL have port gameOver  output  1  game finished.
REQ-016 SHALL have port winner  output  1  0 = left, 1 = right; valid while gameOver=1.
REQ-017 SHALL have port state  output  3  FSM state, debug: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.

Function
REQ-018 SHALL compute startEdge = startBtn & ~startBtn_q, where startBtn_q is startBtn registered one clk.
REQ-019 SHALL, while enable=0, freeze state, frame counter, scores and serveDir; SHALL force ballRun=0 and ballRst=0; startBtn_q SHALL still update.
REQ-020 IDLE: ballRun=0; on startEdge, SHALL clear scores, set serveDir=0 and go to SERVE.
REQ-021 SERVE: ballRun=0; SHALL count frameTick pulses; on the clk carrying the SERVE_FRAMES-th tick, SHALL go to PLAY.
REQ-022 PLAY: ballRun=1; SHALL sample missL and missR every clk.
REQ-023 PLAY, missL only: scoreR+1, serveDir=0, go to POINT.
REQ-024 PLAY, missR only: scoreL+1, serveDir=1, go to POINT.
REQ-025 PLAY, missL and missR in the same clk: no score change, serveDir unchanged, go to POINT.
REQ-026 A miss at PLAY clk n SHALL show the updated score, state=POINT and ballRun=0 at clk n+1.
REQ-027 POINT: ballRun=0; on the POINT_FRAMES-th frameTick, SHALL go to OVER if scoreL or scoreR equals WIN_SCORE, else go to SERVE.
REQ-028 OVER: gameOver=1; winner=1 if scoreR==WIN_SCORE, else 0; scores held; on startEdge, SHALL clear scores, set serveDir=0 and go to SERVE.
REQ-029 ballRst SHALL be a registered pulse, high exactly for the first clk in which state=SERVE, on every SERVE entry.
REQ-030 The frame counter SHALL be 8 bits, cleared on every state change, and incremented only on frameTick.
REQ-031 Scores SHALL never exceed WIN_SCORE; missL/missR SHALL be ignored outside PLAY.
REQ-032 gameOver SHALL be 0 in all states except OVER; winner SHALL be 0 outside OVER.
REQ-033 frameTick arriving in the same clk as a state change SHALL NOT be counted in the new state.

Reset
REQ-034 On rst=0, asynchronously: state=IDLE, counter=0, scoreL=scoreR=0, serveDir=0, ballRst=0, ballRun=0, gameOver=0, winner=0, startBtn_q=1.
REQ-035 startBtn_q reset to 1 SHALL ensure a button held through reset release does not start a game.
REQ-036 Reset asserted mid-game SHALL abort immediately to the REQ-034 values, with no further ballRst pulse until the next SERVE entry.

Verification
REQ-037 Start: SERVE_FRAMES=3; enable=1, startBtn 0->1 -> state=1 and ballRst=1 for one clk; after 3 frameTicks -> state=2, ballRun=1.
REQ-038 Score: in PLAY, missR pulse -> next clk scoreL=1, serveDir=1, state=3; after POINT_FRAMES ticks -> state=1 with ballRst pulse.
REQ-039 Win: WIN_SCORE=2; two missL points -> after POINT hold state=4, gameOver=1, winner=1, scoreR=2; held startBtn gives no restart; new edge -> state=1, scores 0.
REQ-040 Simultaneous: missL=missR=1 in the same PLAY clk -> scores unchanged, state=3.
REQ-041 Freeze/reset: enable=0 during SERVE with ticks -> counter and state hold; rst=0 in PLAY -> all outputs 0 immediately, state=0; startBtn held across reset release -> stays IDLE.
